// File: rtl/tri_pkg.sv
// tri_pkg: default coordinate/id widths, coordinate vector type and FSM states
// shared by the tri_inside block and its edge datapath.
package tri_pkg;
    localparam int DEF_D_BITS = 32;
    localparam int DEF_Q_BITS = 16;
    localparam int DEF_M_BITS = 32;
    typedef logic [2:0][DEF_D_BITS-1:0] vec3;
    typedef enum logic [2:0] {IDLE, SUB, CROSS, DOT, WRITE} state_t;
endpackage

// File: rtl/tri_inside_if.sv
// tri_inside_if: upstream FIFO read side and downstream FIFO-style result port.
interface tri_inside_if
    import tri_pkg::*;
#(
    parameter int D_BITS = DEF_D_BITS,
    parameter int M_BITS = DEF_M_BITS
);
    logic [2:0][D_BITS-1:0] in_p_hit, in_v0, in_v1, in_v2, in_normal, out_p_hit;
    logic [M_BITS-1:0] in_triangle_id, out_triangle_id;
    logic in_empty, in_rd_en, out_hit, out_empty, out_rd_en;
    modport slave (
        input  in_p_hit, in_v0, in_v1, in_v2, in_normal, in_triangle_id, in_empty, out_rd_en,
        output in_rd_en, out_hit, out_p_hit, out_triangle_id, out_empty
    );
    modport master (
        output in_p_hit, in_v0, in_v1, in_v2, in_normal, in_triangle_id, in_empty, out_rd_en,
        input  in_rd_en, out_hit, out_p_hit, out_triangle_id, out_empty
    );
endinterface

// File: rtl/tri_edge_dot.sv
// tri_edge_dot: registered edge x vp cross product, then the sign of normal . c
// in fixed point; reused for each of the three triangle edges.
module tri_edge_dot
    import tri_pkg::*;
#(
    parameter int D_BITS = DEF_D_BITS,
    parameter int Q_BITS = DEF_Q_BITS
) (
    input  logic                   clock,
    input  logic                   i_en,
    input  logic [2:0][D_BITS-1:0] i_edge,
    input  logic [2:0][D_BITS-1:0] i_vp,
    input  logic [2:0][D_BITS-1:0] i_normal,
    output logic                   o_neg
);
    localparam int W = D_BITS + 2;
    logic [2:0][D_BITS-1:0] r_c;
    logic signed [W-1:0] w_d;
    // Full-width signed product rescaled by Q_BITS; callers truncate further as needed.
    function automatic logic signed [W-1:0] mq(input logic [D_BITS-1:0] a, input logic [D_BITS-1:0] b);
        logic signed [2*D_BITS-1:0] p;
        p = $signed(a) * $signed(b);
        return W'(p >>> Q_BITS);
    endfunction
    always_ff @(posedge clock)
        if (i_en) begin
            r_c[0] <= D_BITS'(mq(i_edge[1], i_vp[2]) - mq(i_edge[2], i_vp[1]));
            r_c[1] <= D_BITS'(mq(i_edge[2], i_vp[0]) - mq(i_edge[0], i_vp[2]));
            r_c[2] <= D_BITS'(mq(i_edge[0], i_vp[1]) - mq(i_edge[1], i_vp[0]));
        end
    assign w_d   = mq(i_normal[0], r_c[0]) + mq(i_normal[1], r_c[1]) + mq(i_normal[2], r_c[2]);
    assign o_neg = w_d[W-1];
endmodule

// File: rtl/tri_inside.sv
// tri_inside: point-in-triangle test, three edge passes through one shared datapath,
// results queued in a circular buffer. Define TRI_INSIDE_CULL_EN to emit hits only.
module tri_inside
    import tri_pkg::*;
#(
    parameter int D_BITS    = DEF_D_BITS,
    parameter int Q_BITS    = DEF_Q_BITS,
    parameter int M_BITS    = DEF_M_BITS,
    parameter int OUT_DEPTH = 4
) (
    input logic         clock,
    input logic         reset,
    tri_inside_if.slave bus
);
    localparam int AW = $clog2(OUT_DEPTH);
    typedef logic [2:0][D_BITS-1:0] v3_t;
    state_t r_state, w_next;
    v3_t r_p, r_n, r_v0, r_v1, r_v2, r_edge, r_vp, w_va, w_vb;
    logic [M_BITS-1:0] r_id;
    logic [1:0] r_k;
    logic r_miss, w_neg, w_push, w_pop, w_full, w_drop;
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0] r_cnt;
    logic r_hit_m [OUT_DEPTH];
    v3_t r_p_m [OUT_DEPTH];
    logic [M_BITS-1:0] r_id_m [OUT_DEPTH];
`ifdef TRI_INSIDE_CULL_EN
    assign w_drop = r_miss;
`else
    assign w_drop = 1'b0;
`endif
    assign w_full = r_cnt == (AW+1)'(OUT_DEPTH);
    assign w_push = r_state == WRITE && !w_full && !w_drop;
    assign w_pop  = bus.out_rd_en && !bus.out_empty;
    assign w_va   = r_k == 2'd0 ? r_v0 : r_k == 2'd1 ? r_v1 : r_v2;
    assign w_vb   = r_k == 2'd0 ? r_v1 : r_k == 2'd1 ? r_v2 : r_v0;
    assign bus.in_rd_en = reset && r_state == IDLE && !bus.in_empty;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.in_empty ? IDLE : SUB;
            SUB:     w_next = CROSS;
            CROSS:   w_next = DOT;
            DOT:     w_next = r_k == 2'd2 ? WRITE : SUB;
            WRITE:   w_next = (w_full && !w_drop) ? WRITE : IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_miss  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (bus.in_rd_en) begin
                r_k    <= '0;
                r_miss <= 1'b0;
            end
            if (r_state == DOT) begin
                r_miss <= r_miss | w_neg;
                if (r_k != 2'd2) r_k <= r_k + 2'd1;
            end
        end
    always_ff @(posedge clock) begin
        if (bus.in_rd_en) begin
            r_p  <= bus.in_p_hit;
            r_v0 <= bus.in_v0;
            r_v1 <= bus.in_v1;
            r_v2 <= bus.in_v2;
            r_n  <= bus.in_normal;
            r_id <= bus.in_triangle_id;
        end
        if (r_state == SUB)
            for (int i = 0; i < 3; i++) begin
                r_edge[i] <= w_vb[i] - w_va[i];
                r_vp[i]   <= r_p[i] - w_va[i];
            end
    end
    tri_edge_dot #(.D_BITS(D_BITS), .Q_BITS(Q_BITS)) u_edge_dot (
        .clock   (clock),
        .i_en    (r_state == CROSS),
        .i_edge  (r_edge),
        .i_vp    (r_vp),
        .i_normal(r_n),
        .o_neg   (w_neg)
    );
    // Entries are cleared on reset so the head reads as zero while empty after reset.
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                r_hit_m[i] <= 1'b0;
                r_p_m[i]   <= '0;
                r_id_m[i]  <= '0;
            end
        end else begin
            if (w_push) begin
                r_hit_m[r_wp] <= !r_miss;
                r_p_m[r_wp]   <= r_p;
                r_id_m[r_wp]  <= r_id;
                r_wp          <= r_wp + 1'b1;
            end
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    assign bus.out_hit         = r_hit_m[r_rp];
    assign bus.out_p_hit       = r_p_m[r_rp];
    assign bus.out_triangle_id = r_id_m[r_rp];
    assign bus.out_empty       = r_cnt == '0;
endmodule

// File: tb/tb_tri_inside.sv
// tb_tri_inside: directed checks of tri_inside with an upstream FIFO model and
// hand-computed expected hits, ids and latencies.
module tb_tri_inside;
    import tri_pkg::*;
    typedef struct {
        vec3 p, v0, v1, v2, n;
        logic [31:0] id;
    } tri_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0, bad = 0, pops = 0, n = 0;
    logic rd_q;
    tri_t q[$];
    tri_inside_if bus ();
    tri_inside dut (.clock(clk), .reset(rst_n), .bus(bus));
    always #5 clk = ~clk;
    function automatic vec3 mk(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return {z, y, x};
    endfunction
    function automatic tri_t mt(input vec3 p, input logic [31:0] id);
        tri_t t;
        t.p  = p;
        t.v0 = mk(0, 0, 0);
        t.v1 = mk(32'h10000, 0, 0);
        t.v2 = mk(0, 32'h10000, 0);
        t.n  = mk(0, 0, 32'h10000);
        t.id = id;
        return t;
    endfunction
    // Upstream FIFO model: a pop seen at an edge takes effect just after it.
    always @(posedge clk) begin
        rd_q = bus.in_rd_en;
        #1;
        if (rd_q && q.size() > 0) begin
            void'(q.pop_front());
            pops++;
        end
        bus.in_empty = q.size() == 0;
        if (q.size() > 0) begin
            bus.in_p_hit       = q[0].p;
            bus.in_v0          = q[0].v0;
            bus.in_v1          = q[0].v1;
            bus.in_v2          = q[0].v2;
            bus.in_normal      = q[0].n;
            bus.in_triangle_id = q[0].id;
        end
    end
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic wait_rd();
        int i;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.in_rd_en) break;
        end
        chk("rd_en_seen", 128'(i < 40), 128'(1));
    endtask
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!bus.out_empty) break;
        end
    endtask
    task automatic pop_chk(input string tag, input logic hit, input vec3 p, input logic [31:0] id);
        chk({tag, "_empty"}, 128'(bus.out_empty), 128'(0));
        chk({tag, "_hit"}, 128'(bus.out_hit), 128'(hit));
        chk({tag, "_p"}, 128'(bus.out_p_hit), 128'(p));
        chk({tag, "_id"}, 128'(bus.out_triangle_id), 128'(id));
        bus.out_rd_en = 1'b1;
        @(negedge clk);
        bus.out_rd_en = 1'b0;
    endtask
    initial begin
        bus.out_rd_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_empty", 128'(bus.out_empty), 128'(1));
        chk("rst_out_hit", 128'(bus.out_hit), 128'(0));
        chk("rst_out_p", 128'(bus.out_p_hit), 128'(0));
        chk("rst_out_id", 128'(bus.out_triangle_id), 128'(0));
        chk("rst_rd_en", 128'(bus.in_rd_en), 128'(0));
        rst_n = 1'b1;
        // Interior point: hit, 11-cycle latency.
        q.push_back(mt(mk(32'h4000, 32'h4000, 0), 32'h11));
        wait_rd();
        wait_out(n);
        chk("lat_inside", 128'(n), 128'(11));
        pop_chk("inside", 1'b1, mk(32'h4000, 32'h4000, 0), 32'h11);
        chk("drained", 128'(bus.out_empty), 128'(1));
        // Outside point.
        q.push_back(mt(mk(32'h10000, 32'h10000, 0), 32'h12));
        wait_rd();
`ifdef TRI_INSIDE_CULL_EN
        repeat (30) @(negedge clk);
        chk("cull_no_entry", 128'(bus.out_empty), 128'(1));
`else
        wait_out(n);
        chk("lat_outside", 128'(n), 128'(11));
        pop_chk("outside", 1'b0, mk(32'h10000, 32'h10000, 0), 32'h12);
`endif
        // Point on edge v0-v1 counts as inside.
        q.push_back(mt(mk(32'h8000, 0, 0), 32'h13));
        wait_rd();
        wait_out(n);
        chk("lat_edge", 128'(n), 128'(11));
        pop_chk("edge", 1'b1, mk(32'h8000, 0, 0), 32'h13);
        // Back-pressure: six queued, four buffered, fifth held in WRITE.
        pops = 0;
        for (int i = 0; i < 6; i++) q.push_back(mt(mk(32'h2000, 32'h3000, 0), 32'h20 + i));
        repeat (100) @(negedge clk);
        chk("bp_pops", 128'(pops), 128'(5));
        chk("bp_no_rd", 128'(bus.in_rd_en), 128'(0));
        chk("bp_upstream_left", 128'(q.size()), 128'(1));
        pop_chk("bp0", 1'b1, mk(32'h2000, 32'h3000, 0), 32'h20);
        @(negedge clk);
        chk("bp_fifth_written", 128'(bus.in_rd_en), 128'(1));
        @(negedge clk);
        chk("bp_sixth_popped", 128'(pops), 128'(6));
        for (int i = 1; i < 5; i++) pop_chk("bp_drain", 1'b1, mk(32'h2000, 32'h3000, 0), 32'h20 + i);
        wait_out(n);
        pop_chk("bp_last", 1'b1, mk(32'h2000, 32'h3000, 0), 32'h25);
        chk("bp_empty", 128'(bus.out_empty), 128'(1));
        // Reset during DOT of edge 1 with one result already buffered.
        q.push_back(mt(mk(32'h1000, 32'h1000, 0), 32'h2F));
        wait_rd();
        wait_out(n);
        chk("pre_rst_entry", 128'(bus.out_empty), 128'(0));
        pops = 0;
        q.push_back(mt(mk(32'h1000, 32'h1000, 0), 32'h30));
        wait_rd();
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_empty", 128'(bus.out_empty), 128'(1));
        chk("mid_rst_hit", 128'(bus.out_hit), 128'(0));
        chk("mid_rst_id", 128'(bus.out_triangle_id), 128'(0));
        chk("mid_rst_p", 128'(bus.out_p_hit), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_rst_no_entry", 128'(bus.out_empty), 128'(1));
        chk("post_rst_pops", 128'(pops), 128'(1));
        q.push_back(mt(mk(32'h4000, 32'h8000, 0), 32'h31));
        wait_rd();
        wait_out(n);
        chk("lat_resume", 128'(n), 128'(11));
        pop_chk("resume", 1'b1, mk(32'h4000, 32'h8000, 0), 32'h31);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tri_inside.md
TRI_INSIDE -- requirements
Module: tri_inside

Interface
REQ-001 Parameter D_BITS, default 32, signed fixed-point coordinate width.
REQ-002 Parameter Q_BITS, default 16, fractional bits of every coordinate.
REQ-003 Parameter M_BITS, default 32, triangle-id width.
REQ-004 Parameter OUT_DEPTH, default 4, output buffer entries (power of two, >=2).
REQ-005 clock  input  1  single clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 in_p_hit  input  3 x D_BITS  ray/plane hit point [x,y,z].
REQ-008 in_v0, in_v1, in_v2  input  3 x D_BITS each  triangle vertices.
REQ-009 in_normal  input  3 x D_BITS  triangle normal (unnormalised).
REQ-010 in_triangle_id  input  M_BITS  triangle tag.
REQ-011 in_empty  input  1  upstream FIFO empty; inputs valid when 0.
REQ-012 in_rd_en  output  1  one-cycle pop of upstream FIFO.
REQ-013 out_hit  output  1  1 = point inside or on triangle.
REQ-014 out_p_hit  output  3 x D_BITS; out_triangle_id  output  M_BITS; both taken from the head entry.
REQ-015 out_empty  output  1; out_rd_en  input  1  FIFO-style downstream read; out_rd_en while out_empty=1 is ignored.

Function
REQ-016 FSM states: IDLE, SUB, CROSS, DOT, WRITE; edge counter k in {0,1,2}.
REQ-017 IDLE: if in_empty=0, assert in_rd_en for exactly one cycle, latch all inputs, clear k and the miss flag, go SUB.
REQ-018 SUB: register edge = v[(k+1)%3] - v[k] and vp = p_hit - v[k], D_BITS two's-complement wrap.
REQ-019 CROSS: register c = edge x vp; each product is 2*D_BITS wide, arithmetic shift right Q_BITS, truncate to D_BITS.
REQ-020 DOT: d = sum(normal_i * c_i >> Q_BITS), accumulated in D_BITS+2 bits; if d < 0 set miss; if k<2, increment k and go SUB, else go WRITE.
REQ-021 d = 0 (point on edge or vertex) counts as inside.
REQ-022 WRITE: if the output buffer is not full, push {hit = !miss, p_hit, triangle_id} and go IDLE; if full, hold in WRITE with no state change.
REQ-023 Latency from the in_rd_en cycle to out_empty deasserting is 11 cycles (1 + 3x3 + 1) when the buffer is empty and not stalled.
REQ-024 Throughput: one triangle per 11 cycles; no new pop occurs outside IDLE.
REQ-025 Output buffer is a circular buffer with pointers wrapping at OUT_DEPTH. A simultaneous push and pop when full is not possible (the push is blocked). A simultaneous push and pop otherwise keeps the count unchanged.
REQ-026 out_* data is stable while out_empty=0 and out_rd_en=0.

Reset
REQ-027 While reset=0: FSM = IDLE, k=0, miss=0, buffer pointers/count = 0, in_rd_en=0, out_empty=1, out_hit=0, out_p_hit=0, out_triangle_id=0.
REQ-028 Reset asserted mid-triangle discards that triangle and all buffered results; the first pop after release occurs no earlier than the first rising edge with reset=1.

Configuration
REQ-029 Macro TRI_INSIDE_CULL_EN. When defined, WRITE with miss=1 pushes nothing and returns to IDLE (only hits are emitted, out_hit is always 1). When undefined, every input triangle produces exactly one output entry.

Structure
REQ-030 Shared package tri_pkg holds the default D_BITS/Q_BITS/M_BITS constants, a vec3 typedef (3 x signed D_BITS) and the FSM state enum.
REQ-031 One sub-module, tri_edge_dot, contains the registered cross-product and dot-product datapath (the CROSS and DOT stages). tri_inside instantiates it once and reuses it for all three edges.

Verification
REQ-032 Q16.16, v0=(0,0,0), v1=(0x10000,0,0), v2=(0,0x10000,0), n=(0,0,0x10000), p=(0x4000,0x4000,0) -> out_hit=1, out_empty falls 11 cycles after in_rd_en, id echoed.
REQ-033 Same triangle, p=(0x10000,0x10000,0) -> out_hit=0 (macro undefined); with TRI_INSIDE_CULL_EN -> no entry, out_empty stays 1.
REQ-034 Same triangle, p=(0x8000,0,0) (on edge v0-v1) -> out_hit=1.
REQ-035 out_rd_en held 0, 6 triangles queued upstream -> 4 entries buffered, FSM holds in WRITE with the 5th, and 6th is not popped. Then drain 1 -> 5th is written within 1 cycle.
REQ-036 reset pulsed low during DOT of edge 1 -> all outputs return to reset values asynchronously, no output entry for that triangle, normal processing resumes after release.
